// File: rtl/ts_readout_ctrl.sv
// Mic4 temperature sensor sequencer: triggers the front-end, averages 2^AVG_LOG2 samples per
// burst and queues results in an FWFT FIFO. Define TS_CONT_MODE_EN to build periodic bursts.
module ts_readout_ctrl #(
  parameter int TS_COUNT_WIDTH  = 32,
  parameter int WAIT_CYCLES     = 20000,
  parameter int AVG_LOG2        = 2,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clk_100MHz,
  input  logic                      RESET,
  input  logic                      start,
  input  logic                      cont_en,
  input  logic [31:0]               period,
  output logic                      pulse_in,
  input  logic [TS_COUNT_WIDTH-1:0] ts_mem_out,
  input  logic                      fifo_rd_en,
  output logic [TS_COUNT_WIDTH-1:0] fifo_dout,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  output logic                      busy,
  output logic                      overflow,
  input  logic                      overflow_clr
);

  localparam int ACC_W  = TS_COUNT_WIDTH + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int NSAMP  = 1 << AVG_LOG2;
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int PTR_W  = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT, S_CAPTURE, S_PUSH, S_GAP
  } state_t;

  state_t              state;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [SCNT_W-1:0]   smp_cnt;
  logic [ACC_W-1:0]    acc;
  logic                trig_req;

`ifdef TS_CONT_MODE_EN
  logic [31:0]         gap_cnt;
  assign trig_req = start | cont_en;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cont_en, period};
  assign trig_req   = start;
`endif

  always_ff @(posedge clk_100MHz or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      pulse_in <= 1'b0;
      busy     <= 1'b0;
      wait_cnt <= '0;
      smp_cnt  <= '0;
      acc      <= '0;
`ifdef TS_CONT_MODE_EN
      gap_cnt  <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values; the default below makes pulse_in a single-cycle strobe.
      pulse_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig_req) begin
            state    <= S_TRIG;
            pulse_in <= 1'b1;
            busy     <= 1'b1;
            acc      <= '0;
            smp_cnt  <= '0;
          end
        end
        S_TRIG: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (wait_cnt == WCNT_W'(WAIT_CYCLES - 1)) state <= S_CAPTURE;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        S_CAPTURE: begin
          acc     <= acc + ACC_W'(ts_mem_out);
          smp_cnt <= smp_cnt + 1'b1;
          if (smp_cnt == SCNT_W'(NSAMP - 1)) begin
            state <= S_PUSH;
          end else begin
            state    <= S_TRIG;
            pulse_in <= 1'b1;
          end
        end
        S_PUSH: begin
`ifdef TS_CONT_MODE_EN
          if (cont_en) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
`else
          state <= S_IDLE;
          busy  <= 1'b0;
`endif
        end
`ifdef TS_CONT_MODE_EN
        S_GAP: begin
          // Dropping cont_en during the gap ends the sequence instead of starting a burst.
          if (!cont_en) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == period) begin
            state    <= S_TRIG;
            pulse_in <= 1'b1;
            acc      <= '0;
            smp_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result FIFO: extra pointer MSB distinguishes full from empty when the low bits match.
  logic [TS_COUNT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      do_pop;
  logic                      do_push;
  logic                      drop;
  logic [TS_COUNT_WIDTH-1:0] avg_word;

  assign avg_word   = TS_COUNT_WIDTH'(acc >> AVG_LOG2);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign do_pop     = fifo_rd_en && !fifo_empty;
  assign do_push    = (state == S_PUSH) && (!fifo_full || do_pop);
  assign drop       = (state == S_PUSH) && fifo_full && !do_pop;
  assign fifo_dout  = mem[rd_ptr[PTR_W-2:0]];

  always_ff @(posedge clk_100MHz or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      // NOTE: the storage is reset because fifo_dout reads it directly and must be 0 after
      // reset; at this depth the reset fan-out is small.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-2:0]] <= avg_word;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ts_readout_ctrl.sv
// Randomized self-checking bench for ts_readout_ctrl (default build) with a chip model and
// a queue-based reference of the averaged result FIFO.
`timescale 1ns/1ps
module tb_ts_readout_ctrl;

  localparam int W          = 32;
  localparam int WAIT_C     = 200;
  localparam int AVG        = 2;
  localparam int DL2        = 2;
  localparam int NSAMP      = 1 << AVG;
  localparam int DEPTH      = 1 << DL2;
  localparam int SAMPLE_PER = WAIT_C + 2;
  localparam int FIRST_WORD = NSAMP * SAMPLE_PER + 2;
  localparam int PUSH_OFF   = FIRST_WORD - 1;

  logic          clk_100MHz = 1'b0;
  logic          RESET;
  logic          start = 1'b0;
  logic          cont_en = 1'b0;
  logic [31:0]   period = '0;
  logic          pulse_in;
  logic [W-1:0]  ts_mem_out = '0;
  logic          fifo_rd_en = 1'b0;
  logic [W-1:0]  fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic          busy;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  ts_readout_ctrl #(
    .TS_COUNT_WIDTH (W),
    .WAIT_CYCLES    (WAIT_C),
    .AVG_LOG2       (AVG),
    .FIFO_DEPTH_LOG2(DL2)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .RESET       (RESET),
    .start       (start),
    .cont_en     (cont_en),
    .period      (period),
    .pulse_in    (pulse_in),
    .ts_mem_out  (ts_mem_out),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Chip model: each pulse_in returns the next planned sample after a random response delay.
  logic [W-1:0] sample_q[$];
  int           ptimes[$];
  int           resp_cnt = -1;
  logic [W-1:0] resp_val = '0;

  initial forever begin
    @(negedge clk_100MHz);
    if (resp_cnt == 0) ts_mem_out = resp_val;
    if (resp_cnt >= 0) resp_cnt--;
    if (pulse_in === 1'b1) begin
      ptimes.push_back(cyc);
      if (sample_q.size() > 0) begin
        resp_val = sample_q.pop_front();
        resp_cnt = $urandom_range(120, 5);
      end
    end
  end

  // Reference model of the result queue.
  logic [W-1:0] exp_q[$];
  logic         exp_ovf = 1'b0;

  function automatic logic [W-1:0] avg_of(input logic [W-1:0] s[NSAMP]);
    longint unsigned sum;
    sum = 0;
    foreach (s[i]) sum += s[i];
    return W'(sum / NSAMP);
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_empty"}, fifo_empty, exp_q.size() == 0);
    check({tag, "_full"}, fifo_full, exp_q.size() == DEPTH);
    check({tag, "_overflow"}, overflow, exp_ovf);
    if (exp_q.size() > 0) check({tag, "_dout"}, fifo_dout, exp_q[0]);
  endtask

  // One burst from a start pulse; offsets count cycles after the start cycle (0 = unused).
  task automatic run_burst(input logic [W-1:0] s[NSAMP], input int pop_off, input int clr_off,
                           input int xstart_off, input string tag);
    int           off;
    int           t_start;
    int           done_off;
    logic [W-1:0] word;
    word = avg_of(s);
    foreach (s[i]) sample_q.push_back(s[i]);
    ptimes.delete();
    @(negedge clk_100MHz);
    start    = 1'b1;
    t_start  = cyc;
    off      = 0;
    done_off = -1;
    while (off < 3 * FIRST_WORD && done_off < 0) begin
      @(negedge clk_100MHz);
      off++;
      if (busy !== 1'b1) done_off = off;
      start        = (off == xstart_off);
      fifo_rd_en   = (off == pop_off);
      overflow_clr = (off == clr_off);
    end
    start        = 1'b0;
    fifo_rd_en   = 1'b0;
    overflow_clr = 1'b0;
    check({tag, "_busy_drop_cycle"}, done_off, FIRST_WORD);
    check({tag, "_pulse_count"}, ptimes.size(), NSAMP);
    if (ptimes.size() > 0) check({tag, "_first_pulse"}, ptimes[0] - t_start, 1);
    for (int i = 1; i < ptimes.size(); i++)
      check({tag, "_pulse_spacing"}, ptimes[i] - ptimes[i-1], SAMPLE_PER);
    if (pop_off > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    if (clr_off > 0) exp_ovf = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(word);
    else exp_ovf = 1'b1;
    check({tag, "_busy"}, busy, 1'b0);
    check_status(tag);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk_100MHz);
    if (exp_q.size() > 0) check({tag, "_head"}, fifo_dout, exp_q[0]);
    fifo_rd_en = 1'b1;
    @(negedge clk_100MHz);
    fifo_rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check_status(tag);
  endtask

  task automatic rand_samples(output logic [W-1:0] s[NSAMP]);
    for (int i = 0; i < NSAMP; i++) s[i] = ($urandom_range(3, 0) == 0) ? W'($urandom_range(255, 0))
                                                                      : W'($urandom());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s[NSAMP];
    RESET = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    check("rst_pulse_in", pulse_in, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);
    check("rst_dout", fifo_dout, '0);
    RESET = 1'b0;
    repeat (2) @(negedge clk_100MHz);

    // Single burst; a start during busy and a pop on the empty FIFO must both be ignored.
    s = '{32'd100, 32'd102, 32'd104, 32'd106};
    run_burst(s, 50, 0, 300, "single");
    check("single_word", fifo_dout, 32'd103);
    pop_check("pop_single");

    s = '{32'd1, 32'd1, 32'd1, 32'd2};
    run_burst(s, 0, 0, 0, "trunc");
    s = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_burst(s, 0, 0, 0, "maxval");
    check("trunc_word", fifo_dout, 32'd1);
    pop_check("pop_trunc");
    check("max_word", fifo_dout, 32'hFFFF_FFFF);
    pop_check("pop_max");

    // Random bursts with cont_en toggled: it must have no effect in this build.
    for (int b = 0; b < 2; b++) begin
      cont_en = 1'b1;
      period  = 32'($urandom_range(10, 0));
      rand_samples(s);
      run_burst(s, 0, 0, 0, "rand");
      ptimes.delete();
      repeat (20) @(negedge clk_100MHz);
      check("cont_ignored_pulses", ptimes.size(), 0);
      check("cont_ignored_busy", busy, 1'b0);
      cont_en = 1'b0;
      pop_check("pop_rand");
    end

    // Fill past capacity, then pop during PUSH, then drop with a simultaneous clear.
    for (int b = 0; b < DEPTH + 1; b++) begin
      rand_samples(s);
      run_burst(s, 0, 0, 0, "fill");
    end
    rand_samples(s);
    run_burst(s, PUSH_OFF, 0, 0, "pop_on_push");
    rand_samples(s);
    run_burst(s, 0, PUSH_OFF, 0, "clr_vs_drop");
    @(negedge clk_100MHz);
    overflow_clr = 1'b1;
    @(negedge clk_100MHz);
    overflow_clr = 1'b0;
    exp_ovf      = 1'b0;
    check_status("ovf_clr");
    for (int i = 0; i < DEPTH; i++) pop_check("drain");

    // Reset 100 cycles into WAIT with two words queued.
    for (int b = 0; b < 2; b++) begin
      rand_samples(s);
      run_burst(s, 0, 0, 0, "prereset");
    end
    rand_samples(s);
    foreach (s[i]) sample_q.push_back(s[i]);
    @(negedge clk_100MHz);
    start = 1'b1;
    @(negedge clk_100MHz);
    start = 1'b0;
    repeat (101) @(negedge clk_100MHz);
    check("pre_reset_busy", busy, 1'b1);
    RESET = 1'b1;
    #1;
    check("midreset_pulse_in", pulse_in, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_empty", fifo_empty, 1'b1);
    check("midreset_full", fifo_full, 1'b0);
    check("midreset_dout", fifo_dout, '0);
    exp_q.delete();
    sample_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk_100MHz);
    RESET = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    rand_samples(s);
    run_burst(s, 0, 0, 0, "post_reset");
    pop_check("pop_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
